// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter.
// Carries the IF fetch handshake, the MEM load/store handshake, the
// byte-wide RAM port and the two stall requests.
//   slave  : the arbiter side (drives completions, RAM port, stall requests)
//   master : the client/environment side (drives requests and ram_din)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_inst;
  logic              if_done;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  logic              stallreq_from_if;
  logic              stallreq_from_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_inst, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr,
           stallreq_from_if, stallreq_from_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_inst, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr,
           stallreq_from_if, stallreq_from_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single byte-wide RAM port shared by the IF word fetch and the MEM
// 1/2/4-byte load/store. Each access is serialised into byte transactions;
// MEM wins over IF when both are pending in IDLE.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   rdy      : global ready, low freezes the block
//   bus      : mem_port_arbiter_if.slave (requests, completions, RAM port,
//              stallreq_from_if / stallreq_from_mem)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, len_n, len_n_nxt, cnt_inc;
  logic [ADDR_W-1:0] base, base_nxt;
  logic              is_if, is_if_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic [ADDR_W-1:0] ram_a_q, ram_a_nxt;
  logic [7:0]        ram_dout_q, ram_dout_nxt;
  logic              ram_wr_q, ram_wr_nxt;
  logic [31:0]       if_inst_q, if_inst_nxt;
  logic [31:0]       mem_rdata_q, mem_rdata_nxt;
  logic              if_done_q, if_done_nxt;
  logic              mem_done_q, mem_done_nxt;
  logic [31:0]       rd_word;
  logic [1:0]        cap_idx;

  // Byte count for a MEM length code; 11 behaves as a word.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   len_bytes = CNT_W'(1);
      2'b01:   len_bytes = CNT_W'(2);
      default: len_bytes = CNT_W'(4);
    endcase
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    len_n_nxt     = len_n;
    base_nxt      = base;
    is_if_nxt     = is_if;
    wdata_nxt     = wdata;
    ram_a_nxt     = ram_a_q;
    ram_dout_nxt  = ram_dout_q;
    ram_wr_nxt    = 1'b0;
    if_inst_nxt   = if_inst_q;
    mem_rdata_nxt = mem_rdata_q;
    if_done_nxt   = if_done_q;
    mem_done_nxt  = mem_done_q;
    cnt_inc       = cnt + CNT_W'(1);
    // ram_din at edge with count c holds byte c-1 (two-edge read latency).
    cap_idx       = 2'(cnt - CNT_W'(1));
    rd_word       = is_if ? if_inst_q : mem_rdata_q;
    rd_word[{cap_idx, 3'b000} +: 8] = bus.ram_din;

    if (rdy) begin
      if_done_nxt  = 1'b0;
      mem_done_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            base_nxt  = bus.mem_addr;
            len_n_nxt = len_bytes(bus.mem_len);
            is_if_nxt = 1'b0;
            wdata_nxt = bus.mem_wdata;
            cnt_nxt   = '0;
            ram_a_nxt = bus.mem_addr;
            if (bus.mem_we) begin
              state_nxt    = WR;
              ram_dout_nxt = bus.mem_wdata[7:0];
              ram_wr_nxt   = 1'b1;
            end else begin
              state_nxt     = RD;
              mem_rdata_nxt = '0;
            end
          end else if (bus.if_req) begin
            base_nxt    = bus.if_addr;
            len_n_nxt   = CNT_W'(4);
            is_if_nxt   = 1'b1;
            cnt_nxt     = '0;
            ram_a_nxt   = bus.if_addr;
            state_nxt   = RD;
            if_inst_nxt = '0;
          end
        end
        RD: begin
          cnt_nxt = cnt_inc;
          if (cnt != '0) begin
            if (is_if) if_inst_nxt   = rd_word;
            else       mem_rdata_nxt = rd_word;
          end
          if (cnt == len_n) begin
            state_nxt    = DONE;
            cnt_nxt      = '0;
            if_done_nxt  = is_if;
            mem_done_nxt = ~is_if;
          end else if (cnt_inc < len_n) begin
            ram_a_nxt = base + ADDR_W'(cnt_inc);
          end
        end
        WR: begin
          if (cnt_inc < len_n) begin
            cnt_nxt      = cnt_inc;
            ram_a_nxt    = base + ADDR_W'(cnt_inc);
            ram_dout_nxt = wdata[{cnt_inc[1:0], 3'b000} +: 8];
            ram_wr_nxt   = 1'b1;
          end else begin
            state_nxt    = DONE;
            cnt_nxt      = '0;
            mem_done_nxt = 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      len_n       <= '0;
      base        <= '0;
      is_if       <= 1'b0;
      wdata       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      len_n       <= len_n_nxt;
      base        <= base_nxt;
      is_if       <= is_if_nxt;
      wdata       <= wdata_nxt;
      ram_a_q     <= ram_a_nxt;
      ram_dout_q  <= ram_dout_nxt;
      ram_wr_q    <= ram_wr_nxt;
      if_inst_q   <= if_inst_nxt;
      mem_rdata_q <= mem_rdata_nxt;
      if_done_q   <= if_done_nxt;
      mem_done_q  <= mem_done_nxt;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_done  = mem_done_q;

  assign bus.stallreq_from_if  = bus.if_req  & ~if_done_q;
  assign bus.stallreq_from_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Requester-side counterpart of the pipeline stall controller.
- Owns the single byte-wide RAM port and serves two clients: the 32-bit instruction fetch from IF and 1/2/4-byte load/store from MEM.
- Serialises each access into byte transactions.
- Drives stallreq_from_if and stallreq_from_mem, which the stall controller turns into the stall vector.

Parameters:
- ADDR_W, 32, width of all byte addresses and ram_a. Address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes the block
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_inst  out  32  fetched word, little-endian; valid while if_done=1
- if_done  out  1  one-cycle completion pulse for IF
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_len  in  2  00=1 byte, 01=2 bytes, 10=4 bytes; 11 is treated as 4 bytes
- mem_addr  in  ADDR_W  load/store byte address
- mem_wdata  in  32  store data; byte k = bits [8k+7:8k]
- mem_rdata  out  32  load data, zero-extended; valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse for MEM
- ram_din  in  8  RAM read data
- ram_dout  out  8  RAM write data
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- stallreq_from_if  out  1  combinational: if_req & ~if_done
- stallreq_from_mem  out  1  combinational: mem_req & ~mem_done

Behaviour:
- All outputs are registered except the two stallreq outputs.
- Reset values: if_inst=0, mem_rdata=0, if_done=0, mem_done=0, ram_a=0, ram_dout=0, ram_wr=0, state=IDLE, cnt=0.
- Reset aborts any in-flight access immediately. No further RAM write is issued and no done pulse is produced.
- RAM model: ram_a is sampled at a clock edge, and ram_din holds that byte after the edge. A read address driven after edge E is captured from ram_din at edge E+2.
- States:
  - IDLE: requests are sampled here only. mem_req has priority over if_req. Edge E0 accepts the request, latches base address, length N and we, sets cnt=0 and enters RD or WR. IF is always RD with N=4.
  - RD: after E0+k (k=0..N-1), ram_a=base+k and ram_wr=0. Byte k is captured from ram_din at edge E0+k+2 into bits [8k+7:8k]; unfilled upper bits are 0. At E0+N+1 the last byte is captured and the state moves to DONE.
  - WR: after E0+k (k=0..N-1), ram_a=base+k, ram_dout=byte k and ram_wr=1. At E0+N the state moves to DONE with ram_wr=0.
  - DONE: the matching done output is 1 for exactly one cycle, with data valid. The next edge returns to IDLE.
  - Requests are ignored during DONE, so a req still high in the done cycle is not re-accepted. The requester must drop or replace it.
- Latency from acceptance edge to done cycle: load of N bytes = N+2 edges (word fetch = 6); store = N+1 edges.
- Simultaneous if_req and mem_req in IDLE:
  - MEM is served first.
  - IF stays pending with stallreq_from_if=1 throughout the MEM access.
  - IF is accepted at the first IDLE edge after MEM's DONE.
- A request arriving mid-access is held pending, and its stallreq is asserted immediately.
- rdy=0:
  - state, cnt, latched fields and data registers all hold.
  - ram_wr is forced to 0 and ram_a holds.
  - done outputs hold their value.
  - Capture scheduling resumes relative to rdy-high edges only.
- Address wrap: base+k overflowing 2^ADDR_W wraps to 0 without error. Misaligned accesses are legal.

Test Plan:
- IF only: if_addr=0x100 and RAM bytes 0x13,0x05,0x10,0x00 at 0x100..0x103 -> ram_a steps 0x100..0x103. if_done pulses once at acceptance+6 with if_inst=0x00100513. stallreq_from_if=1 until that cycle.
- Store word: mem_we=1, mem_len=10, addr 0x2000, wdata 0xDEADBEEF -> ram_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x2000..0x2003. mem_done pulses at acceptance+5.
- Contention: if_req and mem_req (byte load at 0x40, RAM byte 0x80) rise together -> MEM is served first and mem_rdata=0x00000080. IF is accepted the edge after mem_done. stallreq_from_if stays 1 throughout.
- Halfword load at ADDR_W max address 0xFFFFFFFF -> ram_a sequence 0xFFFFFFFF then 0x00000000. mem_rdata={byte@0,byte@FFFFFFFF} zero-extended.
- rdy deasserted 3 cycles mid-store -> no ram_wr during the freeze. The byte sequence is unchanged, and completion is delayed by exactly 3 cycles.
- rst asserted during the 2nd byte of a word store -> the next cycle has ram_wr=0 and all outputs at reset values. No mem_done is produced. A new request is accepted normally afterward.
